// File: rtl/interrogate_gen.sv
// Multi-channel interrogate generator: per-channel reference synchroniser, delayed interrogate pulse.
// Optional missing-reference watchdog compiled in with `define INTERROGATE_WATCHDOG_EN.
module interrogate_gen #(
  parameter int CHANNELS    = 2,
  parameter int DELAY_CYC   = 1593,
  parameter int PULSE_CYC   = 15,
  parameter int EDGE_MODE   = 0,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] ref_in,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] ref_out,
  output logic [CHANNELS-1:0] int_out,
  output logic [CHANNELS-1:0] ref_fault
);

  localparam int LOAD_CYC = DELAY_CYC + PULSE_CYC;
  localparam int CW       = $clog2(LOAD_CYC + 1);
  localparam logic [CW-1:0] LOAD_V  = CW'(LOAD_CYC);
  localparam logic [CW-1:0] PULSE_V = CW'(PULSE_CYC);

  if (DELAY_CYC < 1 || PULSE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("interrogate_gen: DELAY_CYC, PULSE_CYC and TIMEOUT_CYC must all be >= 1");
  end

  logic [CHANNELS-1:0]         s1_r;
  logic [CHANNELS-1:0]         s2_r;
  logic [CHANNELS-1:0]         edge_s;
  logic [CHANNELS-1:0]         qual_s;
  logic [CHANNELS-1:0]         int_s;
  logic [CHANNELS-1:0][CW-1:0] cnt_r;
  logic [CHANNELS-1:0][CW-1:0] cnt_nxt_s;

  // Two-flop synchroniser for the asynchronous reference sign bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= '0;
      s2_r <= '0;
    end else begin
      s1_r <= ref_in;
      s2_r <= s1_r;
    end
  end

  assign ref_out = s2_r;

  // Edge detect and qualification by polarity
  always_comb begin
    edge_s = s1_r ^ s2_r;
    qual_s = '0;
    case (EDGE_MODE)
      32'sd1:  qual_s = edge_s & s1_r;
      32'sd2:  qual_s = edge_s & ~s1_r;
      default: qual_s = edge_s;
    endcase
  end

  // Delay/pulse down-counter next state; a new edge always restarts the full delay
  always_comb begin
    cnt_nxt_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!enable[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (qual_s[i]) begin
        cnt_nxt_s[i] = LOAD_V;
      end else if (cnt_r[i] != '0) begin
        cnt_nxt_s[i] = cnt_r[i] - CW'(1);
      end else begin
        cnt_nxt_s[i] = '0;
      end
    end
  end

  // Counter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Pulse decode from the registered count so reset drops it asynchronously
  always_comb begin
    int_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      int_s[i] = (cnt_r[i] != '0) && (cnt_r[i] <= PULSE_V);
    end
  end

  assign int_out = int_s;

`ifdef INTERROGATE_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] TIMEOUT_V = WW'(TIMEOUT_CYC);

  logic [CHANNELS-1:0][WW-1:0] wd_r;
  logic [CHANNELS-1:0][WW-1:0] wd_nxt_s;
  logic [CHANNELS-1:0]         fault_r;
  logic [CHANNELS-1:0]         fault_nxt_s;

  // Saturating edge-to-edge timer; any synchronised transition restarts it
  always_comb begin
    wd_nxt_s    = '0;
    fault_nxt_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (edge_s[i]) begin
        wd_nxt_s[i] = '0;
      end else if (wd_r[i] == TIMEOUT_V) begin
        wd_nxt_s[i] = TIMEOUT_V;
      end else begin
        wd_nxt_s[i] = wd_r[i] + WW'(1);
      end
      fault_nxt_s[i] = (wd_nxt_s[i] == TIMEOUT_V);
    end
  end

  // Watchdog timer and fault flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_r    <= '0;
      fault_r <= '0;
    end else begin
      wd_r    <= wd_nxt_s;
      fault_r <= fault_nxt_s;
    end
  end

  assign ref_fault = fault_r;
`else
  assign ref_fault = '0;
`endif

endmodule

// File: tb/tb_interrogate_gen.sv
// Scoreboard bench for interrogate_gen: three instances (EDGE_MODE 0/1/2) against a timeline model.
// The model tracks the last qualified trigger and last disable time per channel.
module tb_interrogate_gen;

  localparam int D  = 1593;
  localparam int P  = 15;
  localparam int TO = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] ref_in = 2'b00;
  logic [1:0] enable = 2'b11;
  logic [2:0][1:0] ro, io, rf;

  always #5 clk = ~clk;

  interrogate_gen #(.CHANNELS(2), .DELAY_CYC(D), .PULSE_CYC(P), .EDGE_MODE(0), .TIMEOUT_CYC(TO)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .enable(enable),
    .ref_out(ro[0]), .int_out(io[0]), .ref_fault(rf[0]));
  interrogate_gen #(.CHANNELS(2), .DELAY_CYC(D), .PULSE_CYC(P), .EDGE_MODE(1), .TIMEOUT_CYC(TO)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .enable(enable),
    .ref_out(ro[1]), .int_out(io[1]), .ref_fault(rf[1]));
  interrogate_gen #(.CHANNELS(2), .DELAY_CYC(D), .PULSE_CYC(P), .EDGE_MODE(2), .TIMEOUT_CYC(TO)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .enable(enable),
    .ref_out(ro[2]), .int_out(io[2]), .ref_fault(rf[2]));

  typedef struct {
    logic [2:0][1:0] ro;
    logic [2:0][1:0] io;
    logic [2:0][1:0] rf;
    int              cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: raw samples seen at the last two edges, trigger/disable times.
  logic [1:0] p1 = 2'b00;
  logic [1:0] p2 = 2'b00;
  int  n = 0;
  int  last_trig [3][2];
  int  last_dis  [3][2];
  bit  trig_valid[3][2];
  int  wd[2];
  logic [1:0] rv = 2'b00;
  logic [1:0] ev = 2'b11;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    p1 = 2'b00;
    p2 = 2'b00;
    for (int m = 0; m < 3; m++) begin
      for (int c = 0; c < 2; c++) begin
        last_trig[m][c]  = 0;
        last_dis[m][c]   = -1;
        trig_valid[m][c] = 1'b0;
      end
    end
    wd[0] = 0;
    wd[1] = 0;
  endtask

  // One clock: drive inputs, apply the edge to the model, push the expected outputs.
  task automatic cycle(input logic [1:0] r, input logic [1:0] e);
    exp_t x;
    bit tog, qual;
    ref_in = r;
    enable = e;
    @(posedge clk);
    n++;
    for (int c = 0; c < 2; c++) begin
      tog = (p1[c] != p2[c]);
      for (int m = 0; m < 3; m++) begin
        qual = tog && ((m == 0) || (m == 1 && p1[c]) || (m == 2 && !p1[c]));
        if (!e[c]) last_dis[m][c] = n;
        else if (qual) begin
          last_trig[m][c]  = n;
          trig_valid[m][c] = 1'b1;
        end
      end
      if (tog) wd[c] = 0;
      else if (wd[c] < TO) wd[c]++;
    end
    p2 = p1;
    p1 = r;
    for (int m = 0; m < 3; m++) begin
      for (int c = 0; c < 2; c++) begin
        x.ro[m][c] = p2[c];
        x.io[m][c] = trig_valid[m][c] && (last_dis[m][c] < last_trig[m][c]) &&
                     (n - last_trig[m][c] >= D) && (n - last_trig[m][c] <= D + P - 1);
`ifdef INTERROGATE_WATCHDOG_EN
        x.rf[m][c] = (wd[c] == TO);
`else
        x.rf[m][c] = 1'b0;
`endif
      end
    end
    x.cyc = n;
    #1;
    q.push_back(x);
  endtask

  task automatic run(input int cycles);
    repeat (cycles) cycle(rv, ev);
  endtask

  // Asynchronous reset pulse mid-cycle with the reference held high through it.
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst_int_m%0d", m), io[m], 2'b00);
      chk($sformatf("rst_ref_m%0d", m), ro[m], 2'b00);
      chk($sformatf("rst_fault_m%0d", m), rf[m], 2'b00);
    end
    ref_in = 2'b11;
    rv = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: pop and compare one expected record per presented output cycle.
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("ref_out_m%0d_c%0d", m, x.cyc), ro[m], x.ro[m]);
        chk($sformatf("int_out_m%0d_c%0d", m, x.cyc), io[m], x.io[m]);
        chk($sformatf("ref_fault_m%0d_c%0d", m, x.cyc), rf[m], x.rf[m]);
      end
    end
  end

  initial begin
    int rate;
    model_reset();
    #3;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("init_int_m%0d", m), io[m], 2'b00);
      chk($sformatf("init_ref_m%0d", m), ro[m], 2'b00);
      chk($sformatf("init_fault_m%0d", m), rf[m], 2'b00);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(20);
    rv = 2'b01; run(1700);                       // ch0 rising edge, ch1 quiet
    rv = 2'b00; run(1600);                       // ch0 falling edge
    rv = 2'b01; run(1700);                       // second edge lands mid-pulse
    rv = 2'b11; run(1598);                       // ch1 edge, 5 cycles into pulse next
    ev = 2'b01; run(30);                         // disable ch1 mid-pulse
    rv = 2'b01; run(1700);                       // ch1 edge while disabled
    ev = 2'b11; rv = 2'b11; run(1700);           // re-enable plus new edge
    rv = 2'b00; run(1600);                       // both channels mid-pulse
    async_reset();
    run(1700);                                   // pulse from reference held through reset
    run(4300);                                   // no edges: watchdog window

    rate = 2500;
    for (int i = 0; i < 30000; i++) begin
      if (i % 5000 == 0) begin
        case ($urandom_range(0, 2))
          0:       rate = 2500;
          1:       rate = 300;
          default: rate = 3;
        endcase
      end
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, rate) == 0) rv[c] = ~rv[c];
        if ($urandom_range(0, 2999) == 0) ev[c] = ~ev[c];
      end
      cycle(rv, ev);
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected records left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
